// File: rtl/sifted_key_packer.sv
// Packs the bits kept by basis sifting into dense W-bit words over a valid/ready handshake.
// Optional KEY_PARITY_EN adds key_parity, the XOR of all accepted key bits of the frame.
module sifted_key_packer #(
    parameter int unsigned N = 80,
    parameter int unsigned W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N-1:0]             sifted_valid,
    input  logic [N-1:0]             sifted_sender,
    output logic                     busy,
    output logic [W-1:0]             key_word,
    output logic [$clog2(W+1)-1:0]   key_word_bits,
    output logic                     key_word_valid,
    input  logic                     key_word_ready,
    output logic [$clog2(N+1)-1:0]   key_len,
    output logic                     done
`ifdef KEY_PARITY_EN
    ,
    output logic                     key_parity
`endif
);

    localparam int unsigned IdxW  = $clog2(N + 1);
    localparam int unsigned BitsW = $clog2(W + 1);
    localparam int unsigned AccW  = $clog2(W);

    typedef enum logic [2:0] {StIdle, StScan, StEmit, StFlush, StDone} state_e;

    state_e             state_q;
    logic [N-1:0]       valid_q;
    logic [N-1:0]       sender_q;
    logic [IdxW-1:0]    idx_q;
    logic [BitsW-1:0]   fill_q;
    logic [W-1:0]       acc_q;
    logic               busy_q;
    logic [W-1:0]       word_q;
    logic [BitsW-1:0]   bits_q;
    logic               wvalid_q;
    logic [IdxW-1:0]    len_q;
    logic               done_q;
    logic               parity_q;

    logic               cur_valid;
    logic               cur_bit;
    logic               last_pos;
    logic [BitsW-1:0]   fill_nxt;
    logic [W-1:0]       acc_nxt;

    always_comb begin
        cur_valid = valid_q[idx_q];
        cur_bit   = sender_q[idx_q];
        last_pos  = (idx_q == IdxW'(N - 1));
        fill_nxt  = fill_q + BitsW'(cur_valid);
        acc_nxt   = acc_q;
        if (cur_valid) begin
            acc_nxt[fill_q[AccW-1:0]] = cur_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            valid_q  <= '0;
            sender_q <= '0;
            idx_q    <= '0;
            fill_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            word_q   <= '0;
            bits_q   <= '0;
            wvalid_q <= 1'b0;
            len_q    <= '0;
            done_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        valid_q  <= sifted_valid;
                        sender_q <= sifted_sender;
                        idx_q    <= '0;
                        fill_q   <= '0;
                        acc_q    <= '0;
                        len_q    <= '0;
                        parity_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StScan;
                    end
                end
                StScan: begin
                    if (cur_valid) begin
                        acc_q    <= acc_nxt;
                        fill_q   <= fill_nxt;
                        len_q    <= len_q + IdxW'(1);
                        parity_q <= parity_q ^ cur_bit;
                    end
                    idx_q <= idx_q + IdxW'(1);
                    if (fill_nxt == BitsW'(W)) begin
                        word_q   <= acc_nxt;
                        bits_q   <= BitsW'(W);
                        wvalid_q <= 1'b1;
                        state_q  <= StEmit;
                    end else if (last_pos) begin
                        if (fill_nxt != '0) begin
                            // Unused upper accumulator bits are already zero.
                            word_q   <= acc_nxt;
                            bits_q   <= fill_nxt;
                            wvalid_q <= 1'b1;
                            state_q  <= StFlush;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StEmit: begin
                    if (key_word_ready) begin
                        wvalid_q <= 1'b0;
                        fill_q   <= '0;
                        acc_q    <= '0;
                        state_q  <= (idx_q == IdxW'(N)) ? StDone : StScan;
                    end
                end
                StFlush: begin
                    if (key_word_ready) begin
                        wvalid_q <= 1'b0;
                        fill_q   <= '0;
                        acc_q    <= '0;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy           = busy_q;
    assign key_word       = word_q;
    assign key_word_bits  = bits_q;
    assign key_word_valid = wvalid_q;
    assign key_len        = len_q;
    assign done           = done_q;
`ifdef KEY_PARITY_EN
    assign key_parity     = parity_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_sifted_key_packer.sv
// Directed self-checking bench for sifted_key_packer; expected values are hand-computed.
module tb_sifted_key_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [79:0] sifted_valid = '0;
    logic [79:0] sifted_sender = '0;
    logic        key_word_ready = 1'b1;
    logic        busy;
    logic [7:0]  key_word;
    logic [3:0]  key_word_bits;
    logic        key_word_valid;
    logic [6:0]  key_len;
    logic        done;
`ifdef KEY_PARITY_EN
    logic        key_parity;
`endif

    sifted_key_packer #(.N(80), .W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .sifted_valid  (sifted_valid),
        .sifted_sender (sifted_sender),
        .busy          (busy),
        .key_word      (key_word),
        .key_word_bits (key_word_bits),
        .key_word_valid(key_word_valid),
        .key_word_ready(key_word_ready),
        .key_len       (key_len),
        .done          (done)
`ifdef KEY_PARITY_EN
        ,
        .key_parity    (key_parity)
`endif
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail = 0;
    logic [7:0] words[$];
    int wbits[$];
    int done_edge, done_cnt, busy_bad, stall_bad;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame; samples and drives 1 time unit after each rising edge (start edge = 0).
    task automatic run_frame(input logic [79:0] v, input logic [79:0] s, input int stall,
                             input bit poke);
        int stall_left;
        int edge_n;
        bit holding;
        logic [7:0] held;
        words.delete();
        wbits.delete();
        done_edge = -1;
        done_cnt = 0;
        busy_bad = 0;
        stall_bad = 0;
        stall_left = stall;
        holding = 1'b0;
        held = '0;
        key_word_ready = 1'b1;
        @(negedge clk);
        sifted_valid = v;
        sifted_sender = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sifted_valid = ~v;
        sifted_sender = ~s;
        edge_n = 0;
        if (busy !== 1'b1) busy_bad++;
        while (edge_n < 400) begin
            @(posedge clk);
            #1;
            edge_n++;
            start = (poke && edge_n == 20);
            if (poke && edge_n == 20) begin
                sifted_valid = '1;
                sifted_sender = '0;
            end
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = edge_n;
            end else if (done_edge < 0 && busy !== 1'b1) begin
                busy_bad++;
            end
            if (done_edge >= 0 && edge_n > done_edge + 2) break;
            if (key_word_valid) begin
                if (stall_left > 0) begin
                    if (!holding) begin
                        held = key_word;
                        holding = 1'b1;
                    end
                    if (key_word !== held || key_len !== 7'd8) stall_bad++;
                    key_word_ready = 1'b0;
                    stall_left--;
                end else begin
                    key_word_ready = 1'b1;
                    words.push_back(key_word);
                    wbits.push_back(int'(key_word_bits));
                end
            end else begin
                key_word_ready = 1'b1;
            end
        end
        start = 1'b0;
        key_word_ready = 1'b1;
    endtask

    logic [79:0] alt;
    int seen_done, seen_valid;

    initial begin
        for (int i = 0; i < 80; i++) alt[i] = (i % 2 == 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", key_word_valid, 0);
        check("rst_len", key_len, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All valid, alternating sender: ten 8'hAA words
        run_frame('1, alt, 0, 1'b0);
        check("all_nwords", words.size(), 10);
        for (int i = 0; i < words.size(); i++) begin
            check("all_word", words[i], 8'hAA);
            check("all_bits", wbits[i], 8);
        end
        check("all_len", key_len, 80);
        check("all_done_cnt", done_cnt, 1);
        check("all_busy", busy_bad, 0);

        // All invalid: no words, done seen just after edge 81 (latched by a consumer on edge 82)
        run_frame('0, '1, 0, 1'b0);
        check("none_nwords", words.size(), 0);
        check("none_len", key_len, 0);
        check("none_done_edge", done_edge, 81);
        check("none_done_cnt", done_cnt, 1);
        check("none_busy", busy_bad, 0);

        // First 12 positions valid: full word then 4-bit flush
        run_frame(80'hFFF, '1, 0, 1'b0);
        check("part_nwords", words.size(), 2);
        if (words.size() == 2) begin
            check("part_w0", words[0], 8'hFF);
            check("part_b0", wbits[0], 8);
            check("part_w1", words[1], 8'h0F);
            check("part_b1", wbits[1], 4);
        end
        check("part_len", key_len, 12);
        check("part_done_cnt", done_cnt, 1);

        // Backpressure on the first word for 5 cycles
        run_frame('1, alt, 5, 1'b0);
        check("bp_stable", stall_bad, 0);
        check("bp_nwords", words.size(), 10);
        for (int i = 0; i < words.size(); i++) check("bp_word", words[i], 8'hAA);
        check("bp_len", key_len, 80);

        // Start pulsed mid-frame with different data is ignored
        run_frame('1, alt, 0, 1'b1);
        check("poke_nwords", words.size(), 10);
        for (int i = 0; i < words.size(); i++) check("poke_word", words[i], 8'hAA);
        check("poke_done_cnt", done_cnt, 1);

        // Reset mid-scan abandons the frame
        @(negedge clk);
        sifted_valid = '1;
        sifted_sender = '1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_word", key_word, 0);
        check("mid_rst_bits", key_word_bits, 0);
        check("mid_rst_valid", key_word_valid, 0);
        check("mid_rst_len", key_len, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        seen_valid = 0;
        repeat (90) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (key_word_valid || busy) seen_valid++;
        end
        check("post_rst_done", seen_done, 0);
        check("post_rst_active", seen_valid, 0);

        run_frame(80'hFFF, '1, 0, 1'b0);
        check("fresh_nwords", words.size(), 2);
        if (words.size() == 2) begin
            check("fresh_w0", words[0], 8'hFF);
            check("fresh_w1", words[1], 8'h0F);
        end
        check("fresh_len", key_len, 12);

`ifdef KEY_PARITY_EN
        run_frame(80'h7, 80'h7, 0, 1'b0);
        check("par_111", key_parity, 1);
        run_frame(80'h7, 80'h3, 0, 1'b0);
        check("par_110", key_parity, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/sifted_key_packer.md
Name: sifted_key_packer

Overview:
- Downstream of the basis-sifting stage. On `start`, captures that stage's 80-bit `sifted_valid` and `sifted_sender` vectors.
- Scans one position per cycle and discards positions whose valid bit is 0.
- Packs the surviving key bits, in order, into W-bit words, emitted over a valid/ready handshake.
- Feeds the error-estimation and privacy-amplification stages, which need a dense key stream, not a sparse masked vector.

Parameters:
- N, 80, number of sifted positions per frame (width of the sifting-stage vectors).
- W, 8, output word width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to capture a frame; honoured only in IDLE.
- sifted_valid  input  N  per-position keep mask from the sifting stage.
- sifted_sender  input  N  per-position key bit; ignored where the valid bit is 0.
- busy  output  1  high in every state except IDLE.
- key_word  output  W  packed key bits, LSB = earliest accepted bit.
- key_word_bits  output  $clog2(W+1)  number of meaningful bits in key_word (W except on the final partial word).
- key_word_valid  output  1  key_word is presented.
- key_word_ready  input  1  consumer accepts the word on a cycle with valid&ready.
- key_len  output  $clog2(N+1)  running count of accepted key bits for the current frame.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0: busy, key_word, key_word_bits, key_word_valid, key_len, done.
  - Internal frame copies, idx, fill and accumulator cleared.
  - Reset mid-frame abandons the frame; no word or done is produced afterwards.
- All outputs are registered. The consumer sees no combinational path from inputs to outputs.
- States: IDLE, SCAN, EMIT, FLUSH, DONE.
- IDLE:
  - When start=1, register both input vectors.
  - Clear idx=0, fill=0, accumulator=0, key_len=0.
  - Go to SCAN.
  - Input vectors are sampled only on this edge; later changes are ignored.
- SCAN (one position per cycle):
  - If valid_q[idx]=1: write sender_q[idx] into accumulator bit [fill]; fill++ and key_len++.
  - Then idx++.
  - If fill reaches W: go to EMIT, with key_word=accumulator, key_word_bits=W, key_word_valid=1.
  - Else if idx was N-1: go to FLUSH if fill>0, otherwise go to DONE.
- EMIT:
  - key_word, key_word_bits and key_word_valid stay stable until valid&ready.
  - No scanning occurs while stalled.
  - On handshake: clear fill and accumulator, drop valid. Go to DONE if idx==N, otherwise back to SCAN.
  - A full word on the last position therefore goes EMIT→DONE with no empty flush.
- FLUSH:
  - Present the accumulator with upper bits zero-padded, key_word_bits=fill, key_word_valid=1.
  - Hold stable until handshake, then go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - key_len holds the frame total and stays held through IDLE until the next start.
  - Go to IDLE.
- start while busy is ignored, with no effect on state or captured data.
- Timing:
  - An all-invalid frame asserts done on the 82nd edge after the start edge: 80 SCAN cycles plus DONE, busy=1 throughout.
  - Each EMIT/FLUSH adds at least one cycle, plus any cycles where ready=0.
- Widths:
  - idx is $clog2(N+1) bits.
  - key_len saturates naturally at N; no overflow is possible.
  - A word of 0 meaningful bits is never emitted.

Optional Feature:
- Macro: KEY_PARITY_EN.
- When defined:
  - Adds output key_parity (1 bit), the XOR of all accepted key bits of the frame.
  - Cleared on start and on reset.
  - Updated in SCAN alongside key_len.
  - Stable and valid while done=1, held until the next start.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- All valid (80'hFF…FF), sender bit i = i%2 → 10 words of 8'hAA, key_word_bits=8 each, no partial word, key_len=80, single done pulse.
- All invalid (80'h0) → no key_word_valid ever, key_len=0, done exactly 82 edges after start, busy high throughout.
- valid = bits 0..11 only, sender=80'hFF…FF → word 8'hFF (bits=8), then 8'h0F (bits=4), key_len=12, then done.
- Backpressure: all valid, ready held 0 for 5 cycles at first EMIT → key_word/valid stable for those cycles, key_len frozen at 8, no bits lost or duplicated, total 10 words.
- Pulse start again mid-frame → ignored, output stream unchanged. Drop rst_n mid-SCAN → all outputs 0 immediately, no done; a fresh start then runs a clean frame.
- KEY_PARITY_EN defined, valid=bits 0..2, sender bits 0..2 = 1,1,1 → key_parity=1 at done; with sender 1,1,0 → 0.
